bram_port_arbiter: RTL and testbench
====================================

Name: bram_port_arbiter

Overview:
Shares the single BRAM port between three requesters: camera pixel writer (cam), inverse-perspective-mapping reader (ipm) and UART command FSM (com, 'p' write / 'r' read).
- Fixed priority cam > ipm > com, with an aging override so UART commands always complete.
- Sits between the requesters and bram; routes read data back with a per-requester valid strobe.

Parameters:
ADDR_W, 16, address width of BRAM and requester buses
DATA_W, 16, data width
RD_LAT, 1, BRAM read latency in cycles (legal 1..4)
MAX_WAIT, 15, cycles com may wait before forced grant (legal 1..255)

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  synchronous active-high reset
cam_req/ipm_req/com_req  in  1 each  request, held until ack
cam_we/ipm_we/com_we  in  1 each  1 = write, 0 = read
cam_addr/ipm_addr/com_addr  in  ADDR_W each  address
cam_wdata/ipm_wdata/com_wdata  in  DATA_W each  write data
cam_ack/ipm_ack/com_ack  out  1 each  one-cycle grant pulse
cam_rvalid/ipm_rvalid/com_rvalid  out  1 each  read data valid on rdata
rdata  out  DATA_W  shared read data (mem_rdata pass-through)
mem_en  out  1  BRAM enable
mem_we  out  1  BRAM write enable
mem_addr  out  ADDR_W  BRAM address
mem_wdata  out  DATA_W  BRAM write data
mem_rdata  in  DATA_W  BRAM read data
grant_id  out  2  owner of current mem cycle (0 none, 1 cam, 2 ipm, 3 com)

Behaviour:
- Reset: all acks, rvalids, mem_en, mem_we 0. mem_addr, mem_wdata, grant_id 0. Aging counter 0. Read tag pipe cleared.
- Reset mid-read: in-flight reads are discarded; no rvalid after reset.
- Eligibility: a requester is eligible in cycle N if req=1 and its ack is not high in cycle N (masks the already-served request). One requester can therefore be granted at most every other cycle.
- Arbitration is combinational on eligibility plus aging state; results are registered at the edge.
  - Winner order: com if com_wait==MAX_WAIT and com eligible; else cam, ipm, com.
- Edge after cycle N with a winner W:
  - mem_en=1; mem_we/addr/wdata copied from W's inputs.
  - W_ack=1 for exactly one cycle; grant_id=W.
- No winner: mem_en=0, mem_we=0, grant_id=0; mem_addr/mem_wdata hold.
- Handshake: requester holds req/we/addr/wdata stable until it sees ack. In the ack cycle it may drop req or present the next request.
- Read return: on a granted read, W_rvalid asserts exactly RD_LAT cycles after the mem_en cycle, for one cycle.
  - rdata = mem_rdata, combinational.
  - Writes produce no rvalid.
  - Back-to-back reads by different owners return in grant order.
- Aging, com_wait (8 bit):
  - Increments each cycle com is eligible but not granted; saturates at MAX_WAIT.
  - Clears to 0 on com grant, and when com_req=0.
- Simultaneous events:
  - All three eligible with com_wait<MAX_WAIT: cam wins.
  - ipm/com wait while cam streams every cycle, i.e. two cam requests alternating with acks.
- Unused requester inputs are ignored; illegal inputs (req dropped before ack) cancel the request silently.

Decomposition:
- Shared header bram_arb_defs.vh: ID_NONE=2'd0, ID_CAM=2'd1, ID_IPM=2'd2, ID_COM=2'd3.
- Sub-module rd_tag_pipe: RD_LAT-deep shift register of {valid, id[1:0]}, synchronous reset clears it. Its output decodes into the three rvalids.
- Priority and aging logic stay in the top.

Test Plan:
1. Single com write: com_req=1, we=1, addr=16'h0005, wdata=16'h2555.
   -> next edge: mem_en=1, mem_we=1, mem_addr=0005, mem_wdata=2555, com_ack for 1 cycle, grant_id=3.
2. com read after test 1: addr=0005, RD_LAT=1, BRAM model.
   -> com_rvalid exactly 1 cycle after the mem_en cycle, rdata=16'h2555; no other rvalid.
3. Simultaneous cam write (addr 0010) and ipm read (addr 0020) in the same cycle.
   -> cam acked first, ipm on the following cycle.
   -> ipm_rvalid RD_LAT later; mem_addr sequence 0010, 0020.
4. Starvation, MAX_WAIT=3:
   - Stimulus: cam and ipm requesting continuously, com_req high.
   - Response: com granted once com_wait reaches 3 (within 4 cycles); com_wait clears afterwards.
5. Reset mid-read, RD_LAT=3:
   - Stimulus: ipm read granted, rst pulsed 1 cycle later.
   - Response: no ipm_rvalid ever; all outputs 0 during and after rst; first post-reset grant is normal.
6. Held request, no double grant: cam_req held high 6 cycles with a constant address.
   -> cam_ack high on alternating cycles only, 3 grants; mem_en pattern 1,0,1,0,1,0.

Source files
------------

// File: rtl/bram_port_arbiter_pkg.sv
// Shared types for the BRAM port arbiter: requester ids, read-return tags
// and the width of the com aging counter.
package bram_port_arbiter_pkg;

   // Owner encoding, also driven on grant_id.
   typedef enum logic [1:0] {
      ID_NONE = 2'd0,
      ID_CAM  = 2'd1,
      ID_IPM  = 2'd2,
      ID_COM  = 2'd3
   } req_id_e;

   // Width of the com aging counter.
   localparam int WAIT_W = 8;

   // One read in flight: who issued it and whether it is a real read.
   typedef struct packed {
      logic    valid;
      req_id_e id;
   } rd_tag_t;

   localparam rd_tag_t TAG_IDLE = '{valid: 1'b0, id: ID_NONE};

   // True when a returning tag belongs to the given requester.
   function automatic logic tag_hits(rd_tag_t tag, req_id_e id);
      return tag.valid && (tag.id == id);
   endfunction

endpackage

// File: rtl/bram_port_arbiter_rd_tag_pipe.sv
// Delay line that tracks outstanding BRAM reads so the read data can be
// tagged with its owner exactly RD_LAT cycles after the mem_en cycle.
module bram_port_arbiter_rd_tag_pipe
   import bram_port_arbiter_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic    clk,
   input  logic    rst,
   input  rd_tag_t tag_i,
   output rd_tag_t tag_o
);

   rd_tag_t stage_q [RD_LAT];

   // Shift the issued-read tag one stage per cycle; reset drops in-flight reads.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: this small array is reset on purpose -- a stale valid bit would
         // raise an rvalid after reset; real data memories are normally left unreset.
         for (int i = 0; i < RD_LAT; i++) begin
            stage_q[i] <= TAG_IDLE;
         end
      end else begin
         stage_q[0] <= tag_i;
         for (int i = 1; i < RD_LAT; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign tag_o = stage_q[RD_LAT-1];

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one BRAM port between the camera writer (cam), the IPM reader (ipm)
// and the UART command FSM (com). Fixed priority cam > ipm > com, with an
// aging override that forces a com grant after MAX_WAIT lost cycles.
module bram_port_arbiter
   import bram_port_arbiter_pkg::*;
#(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 16,
   parameter int RD_LAT   = 1,
   parameter int MAX_WAIT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cam_req,
   input  logic              cam_we,
   input  logic [ADDR_W-1:0] cam_addr,
   input  logic [DATA_W-1:0] cam_wdata,
   output logic              cam_ack,
   output logic              cam_rvalid,
   input  logic              ipm_req,
   input  logic              ipm_we,
   input  logic [ADDR_W-1:0] ipm_addr,
   input  logic [DATA_W-1:0] ipm_wdata,
   output logic              ipm_ack,
   output logic              ipm_rvalid,
   input  logic              com_req,
   input  logic              com_we,
   input  logic [ADDR_W-1:0] com_addr,
   input  logic [DATA_W-1:0] com_wdata,
   output logic              com_ack,
   output logic              com_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        grant_id
);

   localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

   logic              cam_ack_q, ipm_ack_q, com_ack_q;
   logic              cam_ack_d, ipm_ack_d, com_ack_d;
   logic              mem_en_q, mem_we_q;
   logic              mem_en_d, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   req_id_e           grant_id_q, grant_id_d;
   logic [WAIT_W-1:0] com_wait_q, com_wait_d;

   logic    cam_elig, ipm_elig, com_elig, com_force;
   req_id_e win_id;
   rd_tag_t tag_issue, tag_return;

   // A request whose ack is showing this cycle has already been served.
   assign cam_elig  = cam_req && !cam_ack_q;
   assign ipm_elig  = ipm_req && !ipm_ack_q;
   assign com_elig  = com_req && !com_ack_q;
   assign com_force = com_elig && (com_wait_q == MAX_WAIT_C);

   // Pick this cycle's winner: aged com first, then fixed priority.
   always_comb begin
      win_id = ID_NONE;
      if (com_force)     win_id = ID_COM;
      else if (cam_elig) win_id = ID_CAM;
      else if (ipm_elig) win_id = ID_IPM;
      else if (com_elig) win_id = ID_COM;
   end

   // Build the next memory cycle from the winner; address and data hold when idle.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can
      // leave one unassigned and infer a latch.
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      cam_ack_d   = 1'b0;
      ipm_ack_d   = 1'b0;
      com_ack_d   = 1'b0;
      grant_id_d  = win_id;
      unique case (win_id)
         ID_CAM: begin
            mem_en_d    = 1'b1;
            mem_we_d    = cam_we;
            mem_addr_d  = cam_addr;
            mem_wdata_d = cam_wdata;
            cam_ack_d   = 1'b1;
         end
         ID_IPM: begin
            mem_en_d    = 1'b1;
            mem_we_d    = ipm_we;
            mem_addr_d  = ipm_addr;
            mem_wdata_d = ipm_wdata;
            ipm_ack_d   = 1'b1;
         end
         ID_COM: begin
            mem_en_d    = 1'b1;
            mem_we_d    = com_we;
            mem_addr_d  = com_addr;
            mem_wdata_d = com_wdata;
            com_ack_d   = 1'b1;
         end
         ID_NONE: ;
      endcase
   end

   // Age com while it is eligible and losing; a grant or a dropped request clears it.
   always_comb begin
      com_wait_d = com_wait_q;
      if (!com_req || (win_id == ID_COM)) begin
         com_wait_d = '0;
      end else if (com_elig && (com_wait_q < MAX_WAIT_C)) begin
         com_wait_d = com_wait_q + 1'b1;
      end
   end

   // Register the arbitration result and the aging counter.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cam_ack_q   <= 1'b0;
         ipm_ack_q   <= 1'b0;
         com_ack_q   <= 1'b0;
         grant_id_q  <= ID_NONE;
         com_wait_q  <= '0;
      end else begin
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cam_ack_q   <= cam_ack_d;
         ipm_ack_q   <= ipm_ack_d;
         com_ack_q   <= com_ack_d;
         grant_id_q  <= grant_id_d;
         com_wait_q  <= com_wait_d;
      end
   end

   // A read enters the tag pipe during its mem_en cycle and leaves RD_LAT later.
   assign tag_issue = '{valid: mem_en_q && !mem_we_q, id: grant_id_q};

   bram_port_arbiter_rd_tag_pipe #(
      .RD_LAT (RD_LAT)
   ) u_rd_tag_pipe (
      .clk   (clk),
      .rst   (rst),
      .tag_i (tag_issue),
      .tag_o (tag_return)
   );

   assign cam_rvalid = tag_hits(tag_return, ID_CAM);
   assign ipm_rvalid = tag_hits(tag_return, ID_IPM);
   assign com_rvalid = tag_hits(tag_return, ID_COM);
   assign rdata      = mem_rdata;

   assign cam_ack    = cam_ack_q;
   assign ipm_ack    = ipm_ack_q;
   assign com_ack    = com_ack_q;
   assign mem_en     = mem_en_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign grant_id   = grant_id_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: one instance with RD_LAT=1/MAX_WAIT=3 and one
// with RD_LAT=3 sharing the same stimulus, each behind a simple BRAM model.
module tb_bram_port_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        cam_req = 0, cam_we = 0, ipm_req = 0, ipm_we = 0, com_req = 0, com_we = 0;
   logic [15:0] cam_addr = 0, cam_wdata = 0, ipm_addr = 0, ipm_wdata = 0, com_addr = 0, com_wdata = 0;

   // RD_LAT=1 instance
   logic        cam_ack, ipm_ack, com_ack, cam_rvalid, ipm_rvalid, com_rvalid;
   logic        mem_en, mem_we;
   logic [15:0] mem_addr, mem_wdata, mem_rdata, rdata;
   logic [1:0]  grant_id;

   // RD_LAT=3 instance
   logic        cam_ack_3, ipm_ack_3, com_ack_3, cam_rvalid_3, ipm_rvalid_3, com_rvalid_3;
   logic        mem_en_3, mem_we_3;
   logic [15:0] mem_addr_3, mem_wdata_3, mem_rdata_3, rdata_3;
   logic [1:0]  grant_id_3;

   bram_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(1), .MAX_WAIT(3)) dut (
      .clk(clk), .rst(rst),
      .cam_req(cam_req), .cam_we(cam_we), .cam_addr(cam_addr), .cam_wdata(cam_wdata),
      .cam_ack(cam_ack), .cam_rvalid(cam_rvalid),
      .ipm_req(ipm_req), .ipm_we(ipm_we), .ipm_addr(ipm_addr), .ipm_wdata(ipm_wdata),
      .ipm_ack(ipm_ack), .ipm_rvalid(ipm_rvalid),
      .com_req(com_req), .com_we(com_we), .com_addr(com_addr), .com_wdata(com_wdata),
      .com_ack(com_ack), .com_rvalid(com_rvalid),
      .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .grant_id(grant_id)
   );

   bram_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(3), .MAX_WAIT(15)) dut_lat3 (
      .clk(clk), .rst(rst),
      .cam_req(cam_req), .cam_we(cam_we), .cam_addr(cam_addr), .cam_wdata(cam_wdata),
      .cam_ack(cam_ack_3), .cam_rvalid(cam_rvalid_3),
      .ipm_req(ipm_req), .ipm_we(ipm_we), .ipm_addr(ipm_addr), .ipm_wdata(ipm_wdata),
      .ipm_ack(ipm_ack_3), .ipm_rvalid(ipm_rvalid_3),
      .com_req(com_req), .com_we(com_we), .com_addr(com_addr), .com_wdata(com_wdata),
      .com_ack(com_ack_3), .com_rvalid(com_rvalid_3),
      .rdata(rdata_3), .mem_en(mem_en_3), .mem_we(mem_we_3), .mem_addr(mem_addr_3),
      .mem_wdata(mem_wdata_3), .mem_rdata(mem_rdata_3), .grant_id(grant_id_3)
   );

   // BRAM model: 256 words preloaded with addr ^ A5A5, 1- and 3-cycle read paths.
   logic [15:0] mem_model [256];
   logic        mem_ready = 1'b0;
   logic [15:0] rd1, rd3a, rd3b, rd3c;

   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 256; i++) mem_model[i] <= 16'(i) ^ 16'hA5A5;
         mem_ready <= 1'b1;
      end else begin
         if (mem_en && mem_we)    mem_model[mem_addr[7:0]] <= mem_wdata;
         if (mem_en && !mem_we)   rd1  <= mem_model[mem_addr[7:0]];
         if (mem_en_3 && !mem_we_3) rd3a <= mem_model[mem_addr_3[7:0]];
         rd3b <= rd3a;
         rd3c <= rd3b;
      end
   end
   assign mem_rdata   = rd1;
   assign mem_rdata_3 = rd3c;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic sample();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [2:0]  req;        // {com, ipm, cam}
      logic [2:0]  we;         // {com, ipm, cam}
      logic [15:0] cam_addr, cam_wdata, ipm_addr, ipm_wdata, com_addr, com_wdata;
      logic        exp_en, exp_we;
      logic [15:0] exp_addr, exp_wdata;
      logic [2:0]  exp_ack;    // {com, ipm, cam}
      logic [1:0]  exp_gid;
      logic [2:0]  exp_rv;     // {com, ipm, cam}
      logic [15:0] exp_rdata;
   } vec_t;

   localparam int NVEC = 16;
   vec_t vecs [NVEC];

   int          ack_cnt;
   logic [1:0]  gid_seq [4];
   logic        en_pat  [6];

   initial begin
      //           req     we      cam_a    cam_d    ipm_a    ipm_d    com_a    com_d    en we addr     wdata    ack     gid rv      rdata
      vecs[0]  = '{3'b000, 3'b000, 16'h0,   16'h0,   16'h0,   16'h0,   16'h0,   16'h0,   0, 0, 16'h0000, 16'h0000, 3'b000, 0, 3'b000, 16'h0};
      vecs[1]  = '{3'b100, 3'b100, 16'h0,   16'h0,   16'h0,   16'h0,   16'h0005,16'h2555,1, 1, 16'h0005, 16'h2555, 3'b100, 3, 3'b000, 16'h0};
      vecs[2]  = '{3'b000, 3'b000, 16'h0,   16'h0,   16'h0,   16'h0,   16'h0,   16'h0,   0, 0, 16'h0005, 16'h2555, 3'b000, 0, 3'b000, 16'h0};
      vecs[3]  = '{3'b100, 3'b000, 16'h0,   16'h0,   16'h0,   16'h0,   16'h0005,16'h0,   1, 0, 16'h0005, 16'h0000, 3'b100, 3, 3'b000, 16'h0};
      vecs[4]  = '{3'b000, 3'b000, 16'h0,   16'h0,   16'h0,   16'h0,   16'h0,   16'h0,   0, 0, 16'h0005, 16'h0000, 3'b000, 0, 3'b100, 16'h2555};
      vecs[5]  = '{3'b011, 3'b001, 16'h0010,16'h1234,16'h0020,16'h0,   16'h0,   16'h0,   1, 1, 16'h0010, 16'h1234, 3'b001, 1, 3'b000, 16'h0};
      vecs[6]  = '{3'b010, 3'b000, 16'h0,   16'h0,   16'h0020,16'h0,   16'h0,   16'h0,   1, 0, 16'h0020, 16'h0000, 3'b010, 2, 3'b000, 16'h0};
      vecs[7]  = '{3'b000, 3'b000, 16'h0,   16'h0,   16'h0,   16'h0,   16'h0,   16'h0,   0, 0, 16'h0020, 16'h0000, 3'b000, 0, 3'b010, 16'hA585};
      vecs[8]  = '{3'b111, 3'b010, 16'h0010,16'h0,   16'h0030,16'h0F0F,16'h0005,16'h0,   1, 0, 16'h0010, 16'h0000, 3'b001, 1, 3'b000, 16'h0};
      vecs[9]  = '{3'b110, 3'b010, 16'h0,   16'h0,   16'h0030,16'h0F0F,16'h0005,16'h0,   1, 1, 16'h0030, 16'h0F0F, 3'b010, 2, 3'b001, 16'h1234};
      vecs[10] = '{3'b100, 3'b000, 16'h0,   16'h0,   16'h0,   16'h0,   16'h0005,16'h0,   1, 0, 16'h0005, 16'h0000, 3'b100, 3, 3'b000, 16'h0};
      vecs[11] = '{3'b000, 3'b000, 16'h0,   16'h0,   16'h0,   16'h0,   16'h0,   16'h0,   0, 0, 16'h0005, 16'h0000, 3'b000, 0, 3'b100, 16'h2555};
      vecs[12] = '{3'b011, 3'b000, 16'h0010,16'h0,   16'h0020,16'h0,   16'h0,   16'h0,   1, 0, 16'h0010, 16'h0000, 3'b001, 1, 3'b000, 16'h0};
      vecs[13] = '{3'b010, 3'b000, 16'h0,   16'h0,   16'h0020,16'h0,   16'h0,   16'h0,   1, 0, 16'h0020, 16'h0000, 3'b010, 2, 3'b001, 16'h1234};
      vecs[14] = '{3'b000, 3'b000, 16'h0,   16'h0,   16'h0,   16'h0,   16'h0,   16'h0,   0, 0, 16'h0020, 16'h0000, 3'b000, 0, 3'b010, 16'hA585};
      vecs[15] = '{3'b000, 3'b000, 16'h0,   16'h0,   16'h0,   16'h0,   16'h0,   16'h0,   0, 0, 16'h0020, 16'h0000, 3'b000, 0, 3'b000, 16'h0};

      // Reset state
      repeat (3) sample();
      check("reset ctl", {cam_ack, ipm_ack, com_ack, cam_rvalid, ipm_rvalid, com_rvalid,
                          mem_en, mem_we, grant_id}, 32'h0);
      check("reset addr", mem_addr, 32'h0);
      check("reset wdata", mem_wdata, 32'h0);
      check("reset com_wait", dut.com_wait_q, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Table-driven vectors: single ops, cam/ipm collision, three-way, back-to-back reads
      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         {com_req, ipm_req, cam_req} = vecs[i].req;
         {com_we, ipm_we, cam_we}    = vecs[i].we;
         cam_addr = vecs[i].cam_addr;  cam_wdata = vecs[i].cam_wdata;
         ipm_addr = vecs[i].ipm_addr;  ipm_wdata = vecs[i].ipm_wdata;
         com_addr = vecs[i].com_addr;  com_wdata = vecs[i].com_wdata;
         sample();
         check($sformatf("v%0d mem_en", i), mem_en, vecs[i].exp_en);
         check($sformatf("v%0d mem_we", i), mem_we, vecs[i].exp_we);
         check($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].exp_addr);
         check($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].exp_wdata);
         check($sformatf("v%0d acks", i), {com_ack, ipm_ack, cam_ack}, vecs[i].exp_ack);
         check($sformatf("v%0d grant_id", i), grant_id, vecs[i].exp_gid);
         check($sformatf("v%0d rvalids", i), {com_rvalid, ipm_rvalid, cam_rvalid}, vecs[i].exp_rv);
         if (vecs[i].exp_rv != 3'b000)
            check($sformatf("v%0d rdata", i), rdata, vecs[i].exp_rdata);
      end

      // Held cam request: grants on alternate cycles only
      en_pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      ack_cnt = 0;
      @(negedge clk);
      cam_req = 1; cam_we = 1; cam_addr = 16'h0050; cam_wdata = 16'h5A5A;
      for (int k = 0; k < 6; k++) begin
         sample();
         check($sformatf("held mem_en %0d", k), mem_en, en_pat[k]);
         check($sformatf("held cam_ack %0d", k), cam_ack, en_pat[k]);
         if (cam_ack) ack_cnt++;
      end
      check("held grant count", ack_cnt, 3);
      check("held mem_addr", mem_addr, 32'h0050);
      @(negedge clk);
      cam_req = 0; cam_we = 0;
      sample();

      // Starvation: cam and ipm stream, com forced in after three losses (MAX_WAIT=3)
      gid_seq = '{2'd1, 2'd2, 2'd1, 2'd3};
      @(negedge clk);
      cam_req = 1; cam_we = 1; cam_addr = 16'h0041; cam_wdata = 16'h1111;
      ipm_req = 1; ipm_we = 1; ipm_addr = 16'h0042; ipm_wdata = 16'h2222;
      com_req = 1; com_we = 1; com_addr = 16'h0040; com_wdata = 16'h7777;
      for (int k = 0; k < 4; k++) begin
         sample();
         check($sformatf("starve grant %0d", k), grant_id, gid_seq[k]);
         if (k == 2) check("starve com_wait sat", dut.com_wait_q, 32'd3);
      end
      check("starve com_ack", com_ack, 1'b1);
      check("starve com addr", mem_addr, 32'h0040);
      check("starve com_wait cleared", dut.com_wait_q, 32'h0);
      @(negedge clk);
      com_req = 0; com_we = 0;
      sample();
      check("starve after com grant", grant_id, 32'd1);
      check("starve com_wait idle", dut.com_wait_q, 32'h0);
      @(negedge clk);
      cam_req = 0; ipm_req = 0; cam_we = 0; ipm_we = 0;
      repeat (4) sample();

      // Reset mid-read on the RD_LAT=3 instance
      @(negedge clk);
      ipm_req = 1; ipm_we = 0; ipm_addr = 16'h0020;
      sample();
      check("midrd ipm_ack", ipm_ack_3, 1'b1);
      check("midrd mem_en", mem_en_3, 1'b1);
      @(negedge clk);
      ipm_req = 0;
      sample();
      @(negedge clk);
      rst = 1'b1;
      sample();
      check("midrd rst ctl", {cam_ack_3, ipm_ack_3, com_ack_3, cam_rvalid_3, ipm_rvalid_3,
                              com_rvalid_3, mem_en_3, mem_we_3, grant_id_3}, 32'h0);
      check("midrd rst addr", mem_addr_3, 32'h0);
      check("midrd rst wdata", mem_wdata_3, 32'h0);
      check("midrd rst main ctl", {cam_rvalid, ipm_rvalid, com_rvalid, mem_en, grant_id}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         sample();
         check($sformatf("midrd no rvalid %0d", k), {cam_rvalid_3, ipm_rvalid_3, com_rvalid_3}, 32'h0);
      end

      // First grant after reset behaves normally, data returns three cycles later
      @(negedge clk);
      ipm_req = 1; ipm_we = 0; ipm_addr = 16'h0005;
      sample();
      check("post ipm_ack", ipm_ack_3, 1'b1);
      check("post grant_id", grant_id_3, 32'd2);
      check("post mem_addr", mem_addr_3, 32'h0005);
      @(negedge clk);
      ipm_req = 0;
      for (int k = 1; k <= 3; k++) begin
         sample();
         check($sformatf("post ipm_rvalid +%0d", k), ipm_rvalid_3, (k == 3));
         if (k == 3) check("post rdata", rdata_3, 32'h2555);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

endmodule
